running_total_count: RTL and testbench
======================================

# running_total_count

Parametrised running-total-and-count block for push-button data entry. It synchronises and debounces an active-low add button and accepts exactly one event per press. On each accepted press it adds the `value` input to a running total and increments a press count. Wrap or saturate arithmetic is selectable, overflow is sticky, and a synchronous clear is provided. The block replaces the fixed 8-bit enable counter and sits between the board button/switch inputs and the display driver.

## Interface
- `DATA_W`, default 8: width of `value`.
- `TOTAL_W`, default 16: width of `total`; must be ≥ `DATA_W`.
- `COUNT_W`, default 8: width of `count`.
- `DEBOUNCE`, default 4: consecutive low samples required to accept a press; legal range ≥ 1.
- `SAT_MODE`, default 0: 0 = wrap modulo 2^width; 1 = saturate at all-ones.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `add_n` in 1: raw add button, active-low, asynchronous to `clk`.
- `value` in `DATA_W`: operand, unsigned; sampled on the accept edge only.
- `clear` in 1: synchronous, active-high clear of the accumulated state.
- `total` out `TOTAL_W`: running sum, registered.
- `count` out `COUNT_W`: accepted-press count, registered.
- `overflow` out 1: sticky; set when either `total` or `count` wraps or saturates.
- `accept` out 1: one-cycle pulse on each accepted press, registered.

## Operation
- **Synchroniser:** two flops, `s1 <= add_n`, `s2 <= s1`. Both reset to 1 (released).
- **Debounce counter:** `lowcnt` counts consecutive samples with `s2 == 0`. It clears whenever `s2 == 1`. It saturates at `DEBOUNCE`.
- **FSM states:**
  - IDLE: released and armed. Go to ARMING on `s2 == 0`.
  - ARMING: `lowcnt` incrementing.
    - `s2 == 1` returns to IDLE with no event (glitch rejected).
    - When `lowcnt` reaches `DEBOUNCE`, perform the accept and go to HELD.
    - With `DEBOUNCE == 1`, the accept occurs on the first low sample, straight from IDLE.
  - HELD: button still low; no further accepts regardless of duration. Go to IDLE on the first `s2 == 1` sample.
- **Accept edge actions:**
  - `total <= total + value`, with `value` zero-extended.
  - `count <= count + 1`.
  - `accept <= 1` for exactly one cycle.
- **Wrap mode:** results are taken modulo 2^`TOTAL_W` and 2^`COUNT_W`.
- **Saturate mode:** each field clamps independently at all-ones. A field already at all-ones stays there.
- **Overflow:** set on the accept edge whose true sum exceeds the field maximum, in either mode. It is cleared only by `rst` or `clear`.
- **`clear`:** on the next edge, zeroes `total`, `count`, `overflow` and `accept`. The FSM keeps running.
  - `clear` and an accept on the same edge: `clear` wins and the outputs go to 0. The FSM still moves to HELD, so the press is consumed and does not count after the clear.
- **`rst`:** asynchronously forces `total=0`, `count=0`, `overflow=0`, `accept=0`, `s1=s2=1`, `lowcnt=0`, FSM to IDLE.
  - Reset mid-press or mid-debounce discards the press in progress.
  - A button still held low at reset release is treated as a new press and is accepted after the normal latency.

## Timing
- Reset values: all outputs 0.
- **Latency:** let P0 be the first rising edge at which `add_n` is sampled low.
  - `s2` is low after P1.
  - The FSM sees its first low sample at P2.
  - The accept executes at edge P(1+`DEBOUNCE`).
  - `total`, `count` and `accept` are valid immediately after that edge.
- `accept` is high for exactly the one cycle following the accept edge.
- **Minimum press:** `add_n` must stay low for `DEBOUNCE` consecutive sampled edges.
- **Minimum release:** one sampled high edge between presses. Back-to-back presses are therefore spaced at least `DEBOUNCE+1` cycles apart.
- `value` must be stable at the accept edge. Its value at any other edge is ignored.
- `clear` has a one-edge effect with no latency beyond the register.
- No combinational paths from inputs to outputs.

## Test plan
Parameters for all cases unless noted: `DATA_W=8`, `TOTAL_W=12`, `COUNT_W=4`, `DEBOUNCE=3`.
1. **Reset:** `rst=1` for 3 cycles with `add_n=1` → `total=0`, `count=0`, `overflow=0`, `accept=0`. Assert `rst` mid-cycle → outputs are 0 before the next clock edge.
2. **Held press:** `value=5`, `add_n` low for 10 cycles, then high → exactly one `accept` pulse, at edge P4. Result `total=5`, `count=1`. A second 10-cycle press gives `total=10`, `count=2`.
3. **Glitch rejection:** `add_n` low for 2 sampled edges, then high → no `accept`; `total` and `count` unchanged.
4. **Count limit:** 16 presses with `value=1`.
   - `SAT_MODE=0` → `count=0`, `total=16`, `overflow=1`.
   - `SAT_MODE=1` → `count=15`, `total=16`, `overflow=1`.
5. **Total limit:** `COUNT_W=5`, 17 presses with `value=255` (true sum 4335).
   - `SAT_MODE=0` → `total=239`, `count=17`, `overflow=1`.
   - `SAT_MODE=1` → `total=4095`, `count=17`, `overflow=1`.
6. **Clear and reset during a press:**
   - `clear=1` on the accept edge → `total=0`, `count=0`, `overflow=0`; the held press does not count after release.
   - `rst` pulsed during ARMING → no accept.
   - `add_n` held low through `rst` deassertion → one accept at P4 after release.

Source files
------------

// File: rtl/running_total_count.sv
// Push-button running total and press counter: synchronised, debounced active-low
// add button, one accept per press, wrap or saturate arithmetic with sticky overflow.
module running_total_count #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TOTAL_W  = 16,
  parameter int unsigned COUNT_W  = 8,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned SAT_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               add_n,
  input  logic [DATA_W-1:0]  value,
  input  logic               clear,
  output logic [TOTAL_W-1:0] total,
  output logic [COUNT_W-1:0] count,
  output logic               overflow,
  output logic               accept
);

  localparam int unsigned LW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    HELD   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               s1;
  logic               s2;
  logic [LW-1:0]      lowcnt;
  logic [LW:0]        lowcnt_inc;
  logic               low_reached;
  logic               take;

  logic [TOTAL_W:0]   tot_sum;
  logic [COUNT_W:0]   cnt_sum;
  logic               tot_ovf;
  logic               cnt_ovf;
  logic [TOTAL_W-1:0] tot_next;
  logic [COUNT_W-1:0] cnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= add_n;
      s2 <= s1;
    end
  end

  // low_reached counts the current sample, so DEBOUNCE == 1 accepts straight from IDLE
  assign lowcnt_inc  = {1'b0, lowcnt} + (LW + 1)'(1);
  assign low_reached = (lowcnt_inc >= (LW + 1)'(DEBOUNCE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lowcnt <= '0;
    end else if (s2) begin
      lowcnt <= '0;
    end else if (lowcnt_inc <= (LW + 1)'(DEBOUNCE)) begin
      lowcnt <= lowcnt_inc[LW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (!s2) begin
          if (low_reached) begin
            take       = 1'b1;
            state_next = HELD;
          end else begin
            state_next = ARMING;
          end
        end
      end
      ARMING: begin
        if (s2) begin
          state_next = IDLE;
        end else if (low_reached) begin
          take       = 1'b1;
          state_next = HELD;
        end
      end
      HELD: begin
        if (s2) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One extra carry bit per field: the carry is the overflow flag in both modes
  assign tot_sum  = {1'b0, total} + (TOTAL_W + 1)'(value);
  assign cnt_sum  = {1'b0, count} + (COUNT_W + 1)'(1);
  assign tot_ovf  = tot_sum[TOTAL_W];
  assign cnt_ovf  = cnt_sum[COUNT_W];
  assign tot_next = ((SAT_MODE != 0) && tot_ovf) ? '1 : tot_sum[TOTAL_W-1:0];
  assign cnt_next = ((SAT_MODE != 0) && cnt_ovf) ? '1 : cnt_sum[COUNT_W-1:0];

  // clear takes priority over a coincident accept; the FSM still consumes that press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      accept   <= 1'b0;
    end else if (clear) begin
      total    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      accept   <= 1'b0;
    end else begin
      accept <= take;
      if (take) begin
        total    <= tot_next;
        count    <= cnt_next;
        overflow <= overflow | tot_ovf | cnt_ovf;
      end
    end
  end

endmodule

// File: tb/tb_running_total_count.sv
// Bench for running_total_count: four parameter variants driven in parallel and
// compared every cycle against a run-length based behavioural model.
module tb_running_total_count;

  localparam int unsigned DEB  = 3;
  localparam int          TMAX = 4095;

  logic        clk = 1'b0;
  logic        rst;
  logic        add_n;
  logic [7:0]  value;
  logic        clear;

  logic [11:0] tot0, tot1, tot2, tot3;
  logic [3:0]  cnt0, cnt1;
  logic [4:0]  cnt2, cnt3;
  logic        ovf0, ovf1, ovf2, ovf3;
  logic        acc0, acc1, acc2, acc3;

  int n_assert = 0;
  int n_fail   = 0;

  int cw[4]  = '{4, 4, 5, 5};
  int sat[4] = '{0, 1, 0, 1};
  int m_tot[4];
  int m_cnt[4];
  int m_ovf[4];
  int m_acc[4];
  int run_m1;
  int run_m2;

  always #5 clk = ~clk;

  running_total_count #(.DATA_W(8), .TOTAL_W(12), .COUNT_W(4), .DEBOUNCE(DEB), .SAT_MODE(0)) u0 (
    .clk(clk), .rst(rst), .add_n(add_n), .value(value), .clear(clear),
    .total(tot0), .count(cnt0), .overflow(ovf0), .accept(acc0));
  running_total_count #(.DATA_W(8), .TOTAL_W(12), .COUNT_W(4), .DEBOUNCE(DEB), .SAT_MODE(1)) u1 (
    .clk(clk), .rst(rst), .add_n(add_n), .value(value), .clear(clear),
    .total(tot1), .count(cnt1), .overflow(ovf1), .accept(acc1));
  running_total_count #(.DATA_W(8), .TOTAL_W(12), .COUNT_W(5), .DEBOUNCE(DEB), .SAT_MODE(0)) u2 (
    .clk(clk), .rst(rst), .add_n(add_n), .value(value), .clear(clear),
    .total(tot2), .count(cnt2), .overflow(ovf2), .accept(acc2));
  running_total_count #(.DATA_W(8), .TOTAL_W(12), .COUNT_W(5), .DEBOUNCE(DEB), .SAT_MODE(1)) u3 (
    .clk(clk), .rst(rst), .add_n(add_n), .value(value), .clear(clear),
    .total(tot3), .count(cnt3), .overflow(ovf3), .accept(acc3));

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run_m1 = 0;
    run_m2 = 0;
    for (int i = 0; i < 4; i++) begin
      m_tot[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_acc[i] = 0;
    end
  endtask

  // A press is accepted at edge t when the run of low samples ending at edge t-2
  // has just reached DEB samples; longer runs are the same press, already taken.
  task automatic model_edge();
    int run_t;
    bit hit;
    int cmax;
    int s;
    if (rst) begin
      model_reset();
    end else begin
      run_t  = (add_n == 1'b0) ? run_m1 + 1 : 0;
      hit    = (run_m2 == DEB);
      run_m2 = run_m1;
      run_m1 = run_t;
      for (int i = 0; i < 4; i++) begin
        if (clear) begin
          m_tot[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_acc[i] = 0;
        end else begin
          m_acc[i] = hit ? 1 : 0;
          if (hit) begin
            cmax = (1 << cw[i]) - 1;
            s = m_tot[i] + int'(value);
            if (s > TMAX) begin
              m_ovf[i] = 1;
              s = (sat[i] != 0) ? TMAX : s % (TMAX + 1);
            end
            m_tot[i] = s;
            s = m_cnt[i] + 1;
            if (s > cmax) begin
              m_ovf[i] = 1;
              s = (sat[i] != 0) ? cmax : s % (cmax + 1);
            end
            m_cnt[i] = s;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    int ot[4];
    int oc[4];
    int oo[4];
    int oa[4];
    ot[0] = int'(tot0); ot[1] = int'(tot1); ot[2] = int'(tot2); ot[3] = int'(tot3);
    oc[0] = int'(cnt0); oc[1] = int'(cnt1); oc[2] = int'(cnt2); oc[3] = int'(cnt3);
    oo[0] = int'(ovf0); oo[1] = int'(ovf1); oo[2] = int'(ovf2); oo[3] = int'(ovf3);
    oa[0] = int'(acc0); oa[1] = int'(acc1); oa[2] = int'(acc2); oa[3] = int'(acc3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("total[u%0d] t=%0t", i, $time), ot[i], m_tot[i]);
      chk($sformatf("count[u%0d] t=%0t", i, $time), oc[i], m_cnt[i]);
      chk($sformatf("overflow[u%0d] t=%0t", i, $time), oo[i], m_ovf[i]);
      chk($sformatf("accept[u%0d] t=%0t", i, $time), oa[i], m_acc[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic press(input int len, input logic [7:0] v);
    add_n = 1'b0;
    value = v;
    repeat (len) step();
    add_n = 1'b1;
    repeat (5) step();
  endtask

  initial begin
    rst   = 1'b1;
    add_n = 1'b1;
    value = '0;
    clear = 1'b0;
    model_reset();
    repeat (3) step();
    chk("reset_total", int'(tot0), 0);
    chk("reset_accept", int'(acc0), 0);
    rst = 1'b0;
    step();

    // held press twice, then a glitch
    press(10, 8'd5);
    chk("held1_total", int'(tot0), 5);
    chk("held1_count", int'(cnt0), 1);
    press(10, 8'd5);
    chk("held2_total", int'(tot0), 10);
    chk("held2_count", int'(cnt0), 2);
    press(2, 8'd7);
    chk("glitch_total", int'(tot0), 10);
    chk("glitch_count", int'(cnt0), 2);

    // asynchronous reset mid-cycle
    rst = 1'b1;
    model_reset();
    #2;
    check_all();
    chk("async_rst_total", int'(tot0), 0);
    step();
    rst = 1'b0;
    step();

    // count limit
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (16) press(3, 8'd1);
    chk("cnt_lim_wrap_count", int'(cnt0), 0);
    chk("cnt_lim_wrap_total", int'(tot0), 16);
    chk("cnt_lim_wrap_ovf", int'(ovf0), 1);
    chk("cnt_lim_sat_count", int'(cnt1), 15);
    chk("cnt_lim_sat_total", int'(tot1), 16);
    chk("cnt_lim_sat_ovf", int'(ovf1), 1);

    // total limit
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (17) press(4, 8'd255);
    chk("tot_lim_wrap_total", int'(tot2), 239);
    chk("tot_lim_wrap_count", int'(cnt2), 17);
    chk("tot_lim_wrap_ovf", int'(ovf2), 1);
    chk("tot_lim_sat_total", int'(tot3), 4095);
    chk("tot_lim_sat_count", int'(cnt3), 17);
    chk("tot_lim_sat_ovf", int'(ovf3), 1);

    // clear coinciding with the accept edge (P4)
    add_n = 1'b0;
    value = 8'd9;
    repeat (4) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_acc_total", int'(tot0), 0);
    chk("clr_acc_count", int'(cnt0), 0);
    chk("clr_acc_ovf", int'(ovf3), 0);
    repeat (6) step();
    add_n = 1'b1;
    repeat (5) step();
    chk("clr_acc_after_count", int'(cnt0), 0);

    // reset pulsed during debounce
    add_n = 1'b0;
    value = 8'd3;
    repeat (3) step();
    rst = 1'b1;
    model_reset();
    step();
    rst   = 1'b0;
    add_n = 1'b1;
    repeat (6) step();
    chk("rst_arming_count", int'(cnt0), 0);

    // button held low through reset release
    add_n = 1'b0;
    value = 8'd6;
    rst   = 1'b1;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    repeat (6) step();
    add_n = 1'b1;
    repeat (5) step();
    chk("held_rst_total", int'(tot0), 6);
    chk("held_rst_count", int'(cnt0), 1);

    // randomized presses, glitches, gaps, values and clears
    for (int p = 0; p < 60; p++) begin
      int len;
      int gap;
      len = $urandom_range(1, 8);
      gap = $urandom_range(1, 4);
      repeat (len) begin
        add_n = 1'b0;
        value = 8'($urandom);
        clear = ($urandom_range(0, 24) == 0);
        step();
      end
      repeat (gap) begin
        add_n = 1'b1;
        value = 8'($urandom);
        clear = ($urandom_range(0, 24) == 0);
        step();
      end
    end
    clear = 1'b0;
    add_n = 1'b1;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
